spi_slave_dev: RTL and testbench

Byte-oriented SPI mode-0 slave with a small command decoder, one 8-bit data register and a fixed device ID. It sits behind an external SPI master and runs entirely in the fast system clock domain, oversampling `sck`, `mosi` and `_cs`. It supports READ_ID, READ and WRITE commands, transferred MSB first, with multiple commands allowed within one `_cs` assertion.

---
 rtl/spi_slave_dev.sv | 109 ++++++++++
 tb/tb_spi_slave_dev.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_slave_dev.sv
// SPI mode-0 byte slave with READ_ID / READ / WRITE decoder, oversampled in the clk domain.
// Optional: define SPI_MISO_TRISTATE_EN to float miso while deselected or in reset.
module spi_slave_dev #(
  parameter logic [7:0] DEVICE_ID = 8'h5A,
  parameter logic [7:0] DATA_RST  = 8'h00
) (
  input  logic clk,
  input  logic _rst,
  input  logic sck,
  input  logic mosi,
  output logic miso,
  input  logic _cs
);

  localparam logic [7:0] OP_READ_ID = 8'h1D;
  localparam logic [7:0] OP_READ    = 8'hEA;
  localparam logic [7:0] OP_WRITE   = 8'hAD;

  typedef enum logic [2:0] {CMD, ID_OUT, RD_OUT, WR_IN, SKIP} state_t;

  state_t     state_reg, state_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [7:0] rx_reg, rx_next;
  logic [7:0] tx_reg, tx_next;
  logic [7:0] data_reg, data_next;
  logic [1:0] sck_sync, mosi_sync, cs_sync;
  logic       sck_prev;
  logic       sck_rise, sck_fall, cs_high, mosi_s;
  logic [7:0] rx_byte;
  logic       miso_int;

  assign sck_rise = sck_sync[1] & ~sck_prev;
  assign sck_fall = ~sck_sync[1] & sck_prev;
  assign cs_high  = cs_sync[1];
  assign mosi_s   = mosi_sync[1];
  assign rx_byte  = {rx_reg[6:0], mosi_s};

  always_ff @(posedge clk) begin
    if (!_rst) begin
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sck_prev  <= 1'b0;
      state_reg <= CMD;
      cnt_reg   <= 3'd0;
      rx_reg    <= 8'h00;
      tx_reg    <= 8'h00;
      data_reg  <= DATA_RST;
    end else begin
      sck_sync  <= {sck_sync[0], sck};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_sync   <= {cs_sync[0], _cs};
      sck_prev  <= sck_sync[1];
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rx_reg    <= rx_next;
      tx_reg    <= tx_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rx_next    = rx_reg;
    tx_next    = tx_reg;
    data_next  = data_reg;
    miso_int   = 1'b0;

    if (cs_high) begin
      state_next = CMD;
      cnt_next   = 3'd0;
      tx_next    = 8'h00;
    end else if (sck_rise) begin
      rx_next  = rx_byte;
      cnt_next = cnt_reg + 3'd1;
      if (cnt_reg == 3'd7) begin
        case (state_reg)
          CMD: begin
            case (rx_byte)
              OP_READ_ID: begin state_next = ID_OUT; tx_next = DEVICE_ID; end
              OP_READ:    begin state_next = RD_OUT; tx_next = data_reg;  end
              OP_WRITE:   begin state_next = WR_IN; end
              default:    begin state_next = SKIP;   tx_next = 8'h00;     end
            endcase
          end
          WR_IN: begin
            data_next  = rx_byte;
            state_next = CMD;
          end
          default: state_next = CMD;
        endcase
      end
    end else if (sck_fall && cnt_reg != 3'd0) begin
      // The fall right after a byte boundary keeps the freshly loaded MSB on miso.
      tx_next = {tx_reg[6:0], 1'b0};
    end

    if (state_reg == ID_OUT || state_reg == RD_OUT || state_reg == SKIP)
      miso_int = tx_reg[7];
  end

`ifdef SPI_MISO_TRISTATE_EN
  assign miso = (cs_high || !_rst) ? 1'bz : miso_int;
`else
  assign miso = miso_int;
`endif

endmodule

// File: tb/tb_spi_slave_dev.sv
// Randomized bench for spi_slave_dev: a byte-level command model predicts what the master reads back.
module tb_spi_slave_dev;

  logic clk = 1'b0;
  logic _rst, sck, mosi, _cs;
  logic miso;

  spi_slave_dev dut (
    .clk  (clk),
    ._rst (_rst),
    .sck  (sck),
    .mosi (mosi),
    .miso (miso),
    ._cs  (_cs)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: what the next byte from the slave should be
  int         mode;      // 0: expecting command, 1: responding with resp, 2: writing
  logic [7:0] resp;
  logic [7:0] mdata;
  logic       idle_exp;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer_bits(input logic [7:0] b, input int nbits, output logic [7:0] got);
    got = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      wait_clks(5);
      got = {got[6:0], miso};
      sck = 1'b1;
      wait_clks(5);
      sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    logic [7:0] got, want;
    want = (mode == 1) ? resp : 8'h00;
    xfer_bits(b, 8, got);
    check_val(tag, got, want);
    if (mode == 1) begin
      mode = 0;
    end else if (mode == 2) begin
      mdata = b;
      mode  = 0;
    end else begin
      if (b == 8'h1D)      begin mode = 1; resp = 8'h5A; end
      else if (b == 8'hEA) begin mode = 1; resp = mdata; end
      else if (b == 8'hAD) begin mode = 2; end
      else                 begin mode = 1; resp = 8'h00; end
    end
  endtask

  task automatic cs_on();
    _cs = 1'b0;
    wait_clks(5);
  endtask

  task automatic cs_off(input string tag);
    _cs = 1'b1;
    wait_clks(6);
    mode = 0;
    check_val(tag, {7'b0, miso}, {7'b0, idle_exp});
  endtask

  task automatic reset_pulse(input string tag);
    _rst = 1'b0;
    wait_clks(3);
    check_val(tag, {7'b0, miso}, {7'b0, idle_exp});
    _rst  = 1'b1;
    mode  = 0;
    mdata = 8'h00;
    wait_clks(5);
  endtask

  logic [7:0] pick;
  logic [7:0] junk;

  initial begin
`ifdef SPI_MISO_TRISTATE_EN
    idle_exp = 1'bz;
`else
    idle_exp = 1'b0;
`endif
    mode = 0; resp = 8'h00; mdata = 8'h00;
    _rst = 1'b0; _cs = 1'b1; sck = 1'b0; mosi = 1'b0;
    wait_clks(4);
    check_val("reset_miso", {7'b0, miso}, {7'b0, idle_exp});
    _rst = 1'b1;
    wait_clks(4);

    // Directed walk through the basic command set
    cs_on();
    check_val("cmd_idle_miso", {7'b0, miso}, 8'h00);
    send_byte(8'h1D, "id_cmd");
    send_byte(8'h00, "id_resp");
    cs_off("cs_off_1");

    cs_on();
    send_byte(8'hEA, "rd_cmd");
    send_byte(8'h00, "rd_reset_data");
    send_byte(8'hAD, "wr_cmd");
    send_byte(8'hA5, "wr_data");
    send_byte(8'hEA, "rd_cmd2");
    send_byte(8'h00, "rd_a5");
    send_byte(8'h6C, "bad_cmd");
    send_byte(8'hFF, "skip_resp");
    send_byte(8'hEA, "rd_cmd3");
    send_byte(8'h00, "rd_resync");
    cs_off("cs_off_2");

    // Partial byte then deselect
    cs_on();
    xfer_bits(8'hEA, 4, junk);
    cs_off("cs_off_partial");
    cs_on();
    send_byte(8'h1D, "id_cmd_after_abort");
    send_byte(8'h00, "id_after_abort");

    // Reset in the middle of a read response
    send_byte(8'hEA, "rd_cmd_pre_rst");
    xfer_bits(8'h00, 3, junk);
    reset_pulse("rst_mid_rd");
    send_byte(8'hEA, "rd_cmd_post_rst");
    send_byte(8'h00, "rd_post_rst");
    cs_off("cs_off_3");

    // Randomized frames
    for (int f = 0; f < 30; f++) begin
      int nb, endk;
      cs_on();
      nb = $urandom_range(1, 6);
      for (int k = 0; k < nb; k++) begin
        case ($urandom_range(0, 4))
          0: pick = 8'h1D;
          1: pick = 8'hEA;
          2: pick = 8'hAD;
          default: pick = 8'($urandom);
        endcase
        send_byte(pick, $sformatf("rnd_f%0d_b%0d", f, k));
      end
      endk = $urandom_range(0, 5);
      if (endk == 0) begin
        xfer_bits(8'($urandom), $urandom_range(1, 7), junk);
      end else if (endk == 1) begin
        xfer_bits(8'($urandom), $urandom_range(1, 7), junk);
        reset_pulse($sformatf("rnd_f%0d_rst", f));
        send_byte(8'hEA, $sformatf("rnd_f%0d_rdcmd", f));
        send_byte(8'h00, $sformatf("rnd_f%0d_rd", f));
      end
      cs_off($sformatf("rnd_f%0d_idle", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
